// File: rtl/lsu_access_seq_if.sv
// Bundles the MEM-stage request and the word-wide lsu bus that the access sequencer sits between.
// The master is the surrounding environment (pipeline plus lsu) and the slave is the sequencer.
interface lsu_access_seq_if;
    logic        i_req_valid;
    logic        i_req_we;
    logic [2:0]  i_req_op;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_stall;
    logic        o_ld_valid;
    logic [31:0] o_ld_data;
    logic        o_misalign;
    logic [31:0] o_lsu_addr;
    logic [2:0]  o_lsu_op;
    logic        o_lsu_wren;
    logic [31:0] o_st_data;
    logic [31:0] i_ld_data;

    modport master (
        output i_req_valid, i_req_we, i_req_op, i_req_addr, i_req_wdata, i_ld_data,
        input  o_stall, o_ld_valid, o_ld_data, o_misalign,
               o_lsu_addr, o_lsu_op, o_lsu_wren, o_st_data
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_op, i_req_addr, i_req_wdata, i_ld_data,
        output o_stall, o_ld_valid, o_ld_data, o_misalign,
               o_lsu_addr, o_lsu_op, o_lsu_wren, o_st_data
    );
endinterface

// File: rtl/lsu_access_seq.sv
// Turns RISC-V byte/half/word loads and stores into word-aligned accesses on a memory with a
// one-cycle synchronous read: loads take a wait cycle, sub-word stores become read-modify-write.
module lsu_access_seq #(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    lsu_access_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_WAIT  = 2'd1,
        ST_MERGE = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic        req_byte, req_half, req_word;
    logic        req_mis, req_trap, req_go;
    logic [1:0]  req_lane;

    logic [29:0] addr_p1;
    logic [1:0]  lane_p1;
    logic [2:0]  op_p1;
    logic [31:0] wdata_p1;

    // Lane extraction with sign or zero extension; undefined sizes behave as a word.
    function automatic logic [31:0] ld_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [2:0]  op
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (op[1:0])
            2'b00:   r = op[2] ? {24'd0, b} : 32'(b);
            2'b01:   r = op[2] ? {16'd0, h} : 32'(h);
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] st_merge(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        is_byte,
        input logic [15:0] wdata
    );
        logic [31:0] r;
        r = word;
        if (is_byte)
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        else
            r[{lane[1], 4'b0000} +: 16] = wdata;
        return r;
    endfunction

    // Request decode, only meaningful while IDLE.
    always_comb begin
        req_byte = (bus.i_req_op[1:0] == 2'b00);
        req_half = (bus.i_req_op[1:0] == 2'b01);
        req_word = !req_byte && !req_half;
        req_mis  = (req_half && bus.i_req_addr[0]) ||
                   (req_word && (bus.i_req_addr[1:0] != 2'b00));
        req_trap = req_mis && MISALIGN_TRAP;
        req_go   = (state == IDLE) && bus.i_req_valid && !req_trap;
        // Without trapping, the offending low bits are simply cleared.
        if (req_word)
            req_lane = 2'b00;
        else if (req_half)
            req_lane = {bus.i_req_addr[1], 1'b0};
        else
            req_lane = bus.i_req_addr[1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Capture stage: request copy used by LD_WAIT / ST_MERGE.
    always_ff @(posedge i_clk) begin
        if (req_go) begin
            addr_p1  <= bus.i_req_addr[31:2];
            lane_p1  <= req_lane;
            op_p1    <= bus.i_req_op;
            wdata_p1 <= bus.i_req_wdata;
        end
    end

    assign bus.o_lsu_op = 3'b010;

    // Reset gates every strobe so the outputs show their reset values immediately.
    always_comb begin
        state_nxt      = state;
        bus.o_stall    = 1'b0;
        bus.o_ld_valid = 1'b0;
        bus.o_ld_data  = 32'd0;
        bus.o_misalign = 1'b0;
        bus.o_lsu_addr = 32'd0;
        bus.o_lsu_wren = 1'b0;
        bus.o_st_data  = 32'd0;
        if (!i_rst) begin
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        if (req_trap) begin
                            bus.o_misalign = 1'b1;
                        end else begin
                            bus.o_lsu_addr = {bus.i_req_addr[31:2], 2'b00};
                            if (!bus.i_req_we) begin
                                bus.o_stall = 1'b1;
                                state_nxt   = LD_WAIT;
                            end else if (req_word) begin
                                bus.o_lsu_wren = 1'b1;
                                bus.o_st_data  = bus.i_req_wdata;
                            end else begin
                                bus.o_stall = 1'b1;
                                state_nxt   = ST_MERGE;
                            end
                        end
                    end
                end
                LD_WAIT: begin
                    bus.o_lsu_addr = {addr_p1, 2'b00};
                    bus.o_ld_valid = 1'b1;
                    bus.o_ld_data  = ld_extract(bus.i_ld_data, lane_p1, op_p1);
                    state_nxt      = IDLE;
                end
                ST_MERGE: begin
                    bus.o_lsu_addr = {addr_p1, 2'b00};
                    bus.o_lsu_wren = 1'b1;
                    bus.o_st_data  = st_merge(bus.i_ld_data, lane_p1,
                                              (op_p1[1:0] == 2'b00), wdata_p1[15:0]);
                    state_nxt      = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_seq.sv
// Bench for lsu_access_seq: a word memory stands in for the lsu, and a byte-arithmetic model
// predicts stalls, flags, load results and memory contents for directed and random requests.
module tb_lsu_access_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    lsu_access_seq_if bus ();

    lsu_access_seq #(.MISALIGN_TRAP(1'b1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] lsu_mem [0:127] = '{default: 32'd0};
    logic [31:0] ref_mem [0:127] = '{default: 32'd0};

    // 0x2000-0x20FF -> 0..63, 0x7000-0x703F -> 64..79, 0x7800-0x781F -> 80..87
    function automatic int widx(input logic [31:0] a);
        if (a[15:12] == 4'h2)       return int'(a[7:2]);
        else if (a[15:11] == 5'h0E) return 64 + int'(a[5:2]);
        else                        return 80 + int'(a[4:2]);
    endfunction

    function automatic logic is_input(input logic [31:0] a);
        return (a[15:11] == 5'h0F);
    endfunction

    always @(posedge clk) begin
        if (bus.o_lsu_wren && !is_input(bus.o_lsu_addr))
            lsu_mem[widx(bus.o_lsu_addr)] <= bus.o_st_data;
        bus.i_ld_data <= lsu_mem[widx(bus.o_lsu_addr)];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         output int e_stall, output int e_mis, output int e_ldv, output int e_wr,
                         output logic [31:0] e_ld, output logic [31:0] e_wd);
        int size, off;
        logic [31:0] mask, old, val;
        e_stall = 0; e_mis = 0; e_ldv = 0; e_wr = 0; e_ld = 0; e_wd = 0;
        size = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        off  = int'(addr[1:0]);
        if (off % size != 0) begin
            e_mis = 1;
            return;
        end
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        old  = ref_mem[widx(addr)];
        if (!we) begin
            val = (old >> (8 * off)) & mask;
            if (size < 4 && !op[2] && val[8 * size - 1]) val = val | ~mask;
            e_ld = val; e_stall = 1; e_ldv = 1;
        end else begin
            e_wr = 1;
            if (size == 4) begin
                e_wd = wdata;
            end else begin
                e_wd = (old & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
                e_stall = 1;
            end
            if (!is_input(addr)) ref_mem[widx(addr)] = e_wd;
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output logic [31:0] ld_obs, output logic [31:0] wr_obs);
        int e_stall, e_mis, e_ldv, e_wr;
        logic [31:0] e_ld, e_wd, wr_addr;
        int n_stall, n_mis, n_ldv, n_wr, align_bad, done;
        model(we, op, addr, wdata, e_stall, e_mis, e_ldv, e_wr, e_ld, e_wd);
        n_stall = 0; n_mis = 0; n_ldv = 0; n_wr = 0; align_bad = 0; done = 0;
        ld_obs = 0; wr_obs = 0; wr_addr = 0;
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = we;
        bus.i_req_op    = op;
        bus.i_req_addr  = addr;
        bus.i_req_wdata = wdata;
        #1;
        for (int c = 0; c < 4 && done == 0; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (bus.o_stall) n_stall++;
            if (bus.o_misalign) n_mis++;
            if (bus.o_lsu_addr[1:0] != 2'b00) align_bad = 1;
            if (bus.o_ld_valid) begin
                n_ldv++;
                ld_obs = bus.o_ld_data;
            end
            if (bus.o_lsu_wren) begin
                n_wr++;
                wr_obs  = bus.o_st_data;
                wr_addr = bus.o_lsu_addr;
            end
            if (!bus.o_stall) done = 1;
        end
        check($sformatf("completed@%h", addr), done, 1);
        check($sformatf("stall_cycles@%h", addr), n_stall, e_stall);
        check($sformatf("misalign@%h", addr), n_mis, e_mis);
        check($sformatf("ld_valid@%h", addr), n_ldv, e_ldv);
        check($sformatf("writes@%h", addr), n_wr, e_wr);
        check($sformatf("addr_aligned@%h", addr), align_bad, 0);
        if (e_ldv != 0) check($sformatf("ld_data@%h", addr), ld_obs, e_ld);
        if (e_wr != 0) begin
            check($sformatf("st_data@%h", addr), wr_obs, e_wd);
            check($sformatf("st_addr@%h", addr), wr_addr, {addr[31:2], 2'b00});
        end
        @(posedge clk);
        #1;
        check($sformatf("mem@%h", addr), lsu_mem[widx(addr)], ref_mem[widx(addr)]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ld, wr;
        rst = 1'b1;
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = 1'b0;
        bus.i_req_op    = 3'b010;
        bus.i_req_addr  = 32'h0000_2000;
        bus.i_req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_strobes", {bus.o_stall, bus.o_ld_valid, bus.o_misalign, bus.o_lsu_wren}, 4'b0);
        check("rst_lsu_addr", bus.o_lsu_addr, 32'd0);
        check("rst_st_data", bus.o_st_data, 32'd0);
        check("rst_ld_data", bus.o_ld_data, 32'd0);
        check("rst_lsu_op", bus.o_lsu_op, 3'b010);
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_strobes", {bus.o_stall, bus.o_ld_valid, bus.o_misalign, bus.o_lsu_wren}, 4'b0);

        // Aligned word store then load
        do_req(1'b1, 3'b010, 32'h2004, 32'hDEAD_BEEF, ld, wr);
        check("sw_word_data", wr, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b010, 32'h2004, 32'd0, ld, wr);
        check("lw_word", ld, 32'hDEAD_BEEF);

        // Sub-word store read-modify-write
        do_req(1'b1, 3'b010, 32'h2008, 32'h1122_3344, ld, wr);
        do_req(1'b1, 3'b000, 32'h200A, 32'h0000_00AA, ld, wr);
        check("sb_merge", wr, 32'h11AA_3344);
        do_req(1'b0, 3'b101, 32'h200A, 32'd0, ld, wr);
        check("lhu_after_sb", ld, 32'h0000_11AA);

        // Sign and zero extension
        do_req(1'b1, 3'b010, 32'h2020, 32'h80FF_7F01, ld, wr);
        do_req(1'b0, 3'b000, 32'h2023, 32'd0, ld, wr);
        check("lb_plus3", ld, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h2021, 32'd0, ld, wr);
        check("lbu_plus1", ld, 32'h0000_007F);
        do_req(1'b0, 3'b001, 32'h2022, 32'd0, ld, wr);
        check("lh_plus2", ld, 32'hFFFF_80FF);
        do_req(1'b0, 3'b101, 32'h2020, 32'd0, ld, wr);
        check("lhu_plus0", ld, 32'h0000_7F01);

        // Misaligned requests are trapped
        do_req(1'b0, 3'b010, 32'h2001, 32'd0, ld, wr);
        do_req(1'b1, 3'b001, 32'h2003, 32'h0000_CAFE, ld, wr);
        check("mis_mem_unchanged", lsu_mem[widx(32'h2000)], 32'd0);

        // Reset during ST_MERGE abandons the write
        do_req(1'b1, 3'b010, 32'h2010, 32'h5566_7788, ld, wr);
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = 1'b1;
        bus.i_req_op    = 3'b001;
        bus.i_req_addr  = 32'h2010;
        bus.i_req_wdata = 32'h0000_BEEF;
        #1;
        check("rmw_read_stall", bus.o_stall, 1'b1);
        @(negedge clk);
        #1;
        check("rmw_merge_wren", bus.o_lsu_wren, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_merge_strobes", {bus.o_stall, bus.o_ld_valid, bus.o_misalign, bus.o_lsu_wren}, 4'b0);
        check("rst_merge_addr", bus.o_lsu_addr, 32'd0);
        check("rst_merge_st_data", bus.o_st_data, 32'd0);
        bus.i_req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_merge_no_write", lsu_mem[widx(32'h2010)], 32'h5566_7788);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 3'b010, 32'h2010, 32'd0, ld, wr);
        check("after_rst_lw", ld, 32'h5566_7788);

        // Peripheral byte store
        do_req(1'b1, 3'b000, 32'h7001, 32'h0000_003F, ld, wr);
        do_req(1'b0, 3'b010, 32'h7000, 32'd0, ld, wr);
        check("ledr_readback", ld, 32'h0000_3F00);

        // Random back-to-back traffic
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [2:0]  op;
            logic [1:0]  lane;
            int          r;
            op   = 3'($urandom_range(0, 7));
            r    = $urandom_range(0, 9);
            lane = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0) begin
                if (op[1:0] == 2'b01) lane = {lane[1], 1'b0};
                else if (op[1:0] != 2'b00) lane = 2'b00;
            end
            if (r < 7)       a = 32'h2000 + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            else if (r < 9)  a = 32'h7000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            else             a = 32'h7800 + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            a[1:0] = lane;
            do_req(1'($urandom_range(0, 1)), op, a, $urandom, ld, wr);
        end

        @(negedge clk);
        bus.i_req_valid = 1'b0;
        #1;
        check("final_idle", {bus.o_stall, bus.o_ld_valid, bus.o_misalign, bus.o_lsu_wren}, 4'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
